// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential multiplier.
// Holds the controller state encoding and the default operand width.
package mult_pkg;

  localparam int MULT_WIDTH_DEF = 8;

  typedef enum logic {
    ESPERA      = 1'b0,
    MULTIPLICAR = 1'b1
  } state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier: FSM, iteration counter,
// handshake outputs and the per-cycle iteration enable.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  output logic busy_o,
  output logic done_o,
  output logic load_o,
  output logic iter_o,
  output logic last_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ESPERA;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    load_o  = 1'b0;
    iter_o  = 1'b0;
    last_o  = 1'b0;
    case (state_q)
      ESPERA: begin
        ready_o = 1'b1;
        if (valid_i) begin
          load_o  = 1'b1;
          cnt_d   = '0;
          state_d = MULTIPLICAR;
        end
      end
      MULTIPLICAR: begin
        busy_o = 1'b1;
        iter_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last_o  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ESPERA;
      end
    endcase
  end

  assign done_o = done_q;

endmodule

// File: rtl/mult_sec_param.sv
// Iterative WIDTH x WIDTH multiplier, one partial product per cycle.
// Define MULT_SIGNED_EN for two's-complement operands (radix-2 Booth).
module mult_sec_param
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] producto
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int AW    = 2 * WIDTH + 1;

  logic               load, iter, last;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [AW-1:0]      acc_q, acc_d, acc_step;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     hi, m_ext, sum;

  mult_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk_i   (clk),
    .rst_ni  (rst),
    .valid_i (valid),
    .ready_o (ready),
    .busy_o  (busy),
    .done_o  (done),
    .load_o  (load),
    .iter_o  (iter),
    .last_o  (last)
  );

  // acc = {hi[WIDTH:0], multiplier bits still to consume}
  assign hi = acc_q[AW-1:WIDTH];

`ifdef MULT_SIGNED_EN
  logic qm1_q, qm1_d;

  always_comb begin
    m_ext = {a_q[WIDTH-1], a_q};
    case ({acc_q[0], qm1_q})
      2'b01:   sum = hi + m_ext;
      2'b10:   sum = hi - m_ext;
      default: sum = hi;
    endcase
    acc_step = {sum[WIDTH], sum, acc_q[WIDTH-1:1]};
    qm1_d    = qm1_q;
    if (load)      qm1_d = 1'b0;
    else if (iter) qm1_d = acc_q[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) qm1_q <= 1'b0;
    else      qm1_q <= qm1_d;
  end
`else
  always_comb begin
    m_ext    = {1'b0, a_q};
    sum      = acc_q[0] ? hi + m_ext : hi;
    acc_step = {1'b0, sum, acc_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    a_d    = a_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    if (load) begin
      a_d   = a;
      acc_d = {{(WIDTH+1){1'b0}}, b};
    end else if (iter) begin
      acc_d = acc_step;
      if (last) prod_d = acc_step[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
    end
  end

  assign producto = prod_q;

endmodule
